// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: single-cycle hits, dirty-victim writeback,
// four-word line fill from a fixed-latency memory, then replay of the access.
module cache_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int WORDS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err,
    output logic        c_enable,
    output logic        c_comp,
    output logic        c_write,
    output logic        c_valid_in,
    output logic [4:0]  c_tag_in,
    output logic [7:0]  c_index,
    output logic [2:0]  c_offset,
    output logic [15:0] c_data_in,
    input  logic        c_hit,
    input  logic        c_dirty,
    input  logic        c_valid,
    input  logic [4:0]  c_tag_out,
    input  logic [15:0] c_data_out,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_wr,
    output logic        m_rd,
    input  logic        m_stall,
    input  logic [15:0] m_data_out
);

    // state  | meaning
    // IDLE   | accept CPU access, serve hits in the same cycle
    // WB     | write the dirty victim line back, one word per accepted request
    // RDREQ  | issue the four line-fill reads
    // RDWAIT | drain outstanding fill returns into the cache
    // REDO   | replay the latched access against the filled line
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        RDREQ  = 3'd2,
        RDWAIT = 3'd3,
        REDO   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [15:0] lat_addr, lat_data;
    logic        lat_wr;
    logic [1:0]  wcnt, rcnt, fcnt;
    logic [MEM_LAT-1:0]      pv;
    logic [MEM_LAT-1:0][1:0] po;

    logic start_miss, wb_acc, rd_acc, fill_wr;

    assign fill_wr = !rst && pv[MEM_LAT-1] && (state == RDREQ || state == RDWAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
            fcnt     <= '0;
            pv       <= '0;
            po       <= '0;
        end else begin
            state <= state_nxt;
            if (start_miss) begin
                lat_addr <= Addr;
                lat_data <= DataIn;
                lat_wr   <= Wr;
                wcnt     <= '0;
                rcnt     <= '0;
                fcnt     <= '0;
            end
            if (wb_acc)
                wcnt <= wcnt + 2'd1;
            if (rd_acc)
                rcnt <= rcnt + 2'd1;
            if (fill_wr)
                fcnt <= fcnt + 2'd1;
            // return pipeline tracks which word arrives MEM_LAT cycles after each accepted read
            pv[0] <= rd_acc;
            po[0] <= rcnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
            end
        end
    end

    // Cache port drive; kept apart from the status decode so it never depends on cache outputs.
    always_comb begin
        c_enable   = 1'b0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_tag_in   = lat_addr[15:11];
        c_index    = lat_addr[10:3];
        c_offset   = lat_addr[2:0];
        c_data_in  = lat_data;
        if (fill_wr) begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_offset   = {po[MEM_LAT-1], 1'b0};
            c_data_in  = m_data_out;
        end else if (!rst) begin
            case (state)
                IDLE: begin
                    if (Rd ^ Wr) begin
                        c_enable  = 1'b1;
                        c_comp    = 1'b1;
                        c_write   = Wr;
                        c_tag_in  = Addr[15:11];
                        c_index   = Addr[10:3];
                        c_offset  = Addr[2:0];
                        c_data_in = DataIn;
                    end
                end
                WB: begin
                    c_enable = 1'b1;
                    c_offset = {wcnt, 1'b0};
                end
                REDO: begin
                    c_enable = 1'b1;
                    c_comp   = 1'b1;
                    c_write  = lat_wr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        DataOut    = '0;
        Done       = 1'b0;
        Stall      = 1'b0;
        CacheHit   = 1'b0;
        Err        = 1'b0;
        m_addr     = '0;
        m_data_in  = '0;
        m_wr       = 1'b0;
        m_rd       = 1'b0;
        start_miss = 1'b0;
        wb_acc     = 1'b0;
        rd_acc     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (Rd && Wr) begin
                        Err = 1'b1;
                    end else if (Rd ^ Wr) begin
                        if (c_hit && c_valid) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = c_data_out;
                        end else begin
                            start_miss = 1'b1;
                            state_nxt  = (c_valid && c_dirty) ? WB : RDREQ;
                        end
                    end
                end
                WB: begin
                    Stall     = 1'b1;
                    m_wr      = 1'b1;
                    m_addr    = {c_tag_out, lat_addr[10:3], wcnt, 1'b0};
                    m_data_in = c_data_out;
                    wb_acc    = !m_stall;
                    if (!m_stall && wcnt == 2'(WORDS-1))
                        state_nxt = RDREQ;
                end
                RDREQ: begin
                    Stall  = 1'b1;
                    m_rd   = 1'b1;
                    m_addr = {lat_addr[15:3], rcnt, 1'b0};
                    rd_acc = !m_stall;
                    if (!m_stall && rcnt == 2'(WORDS-1))
                        state_nxt = RDWAIT;
                end
                RDWAIT: begin
                    Stall = 1'b1;
                    if (fill_wr && fcnt == 2'(WORDS-1))
                        state_nxt = REDO;
                end
                REDO: begin
                    Done      = 1'b1;
                    DataOut   = lat_wr ? 16'h0 : c_data_out;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl with behavioural cache array,
// fixed-latency memory and an abstract coherent-memory reference model.
module tb_cache_ctrl;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Rd = 1'b0, Wr = 1'b0;
    logic [15:0] Addr = '0, DataIn = '0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, Err;
    logic        c_enable, c_comp, c_write, c_valid_in;
    logic [4:0]  c_tag_in;
    logic [7:0]  c_index;
    logic [2:0]  c_offset;
    logic [15:0] c_data_in;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_tag_out;
    logic [15:0] c_data_out;
    logic [15:0] m_addr, m_data_in;
    logic        m_wr, m_rd;
    logic        m_stall = 1'b0;
    logic [15:0] m_data_out;

    always #5 clk = ~clk;

    cache_ctrl #(.MEM_LAT(MEM_LAT), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err),
        .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_tag_in(c_tag_in), .c_index(c_index), .c_offset(c_offset), .c_data_in(c_data_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
        .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr),
        .m_rd(m_rd), .m_stall(m_stall), .m_data_out(m_data_out)
    );

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, start_stall = 0, stall_total = 0, last_lat = 0;
    int stall_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int a);
        logic [31:0] v;
        v = a * 32'd40503;
        return v[15:0] ^ 16'h3C5A;
    endfunction

    // Behavioural cache array: combinational read, compare-write sets dirty, fill write clears it.
    logic        cv [256] = '{default: 1'b0};
    logic        cd [256] = '{default: 1'b0};
    logic [4:0]  ct [256] = '{default: 5'd0};
    logic [15:0] cw [256][4] = '{default: '{default: 16'h0}};
    logic        inv_req = 1'b0;
    logic [7:0]  inv_idx = '0;

    always_comb begin
        c_hit      = c_enable && (ct[c_index] == c_tag_in);
        c_valid    = c_enable && cv[c_index];
        c_dirty    = c_enable && cd[c_index];
        c_tag_out  = ct[c_index];
        c_data_out = cw[c_index][c_offset[2:1]];
    end

    always @(posedge clk) begin
        if (inv_req) begin
            cv[inv_idx] <= 1'b0;
        end else if (c_enable && c_write) begin
            if (c_comp) begin
                if (cv[c_index] && ct[c_index] == c_tag_in) begin
                    cw[c_index][c_offset[2:1]] <= c_data_in;
                    cd[c_index] <= 1'b1;
                end
            end else begin
                cw[c_index][c_offset[2:1]] <= c_data_in;
                ct[c_index] <= c_tag_in;
                cv[c_index] <= c_valid_in;
                cd[c_index] <= 1'b0;
            end
        end
    end

    // Memory: writes land at acceptance, reads return MEM_LAT cycles after acceptance.
    logic [15:0] mem [int];
    logic [15:0] dp0 = '0, dp1 = '0;
    assign m_data_out = dp1;

    function automatic logic [15:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        dp1 <= dp0;
        if (m_rd && !m_stall)
            dp0 <= mem_rd(int'(m_addr[15:1]));
        if (m_wr && !m_stall)
            mem[int'(m_addr[15:1])] = m_data_in;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (stall_mode)
                1:       m_stall = ($urandom_range(0, 2) == 0);
                2:       m_stall = ((cyc - start_cyc) >= 2) && ((cyc - start_cyc) <= 4);
                default: m_stall = 1'b0;
            endcase
        end
    end

    // Reference model: CPU-visible memory plus which tag each index holds and whether it is dirty.
    logic [15:0] gold [int];
    logic        rv [256];
    logic        rdty [256];
    logic [4:0]  rt [256];

    function automatic logic [15:0] gold_rd(input int a);
        return gold.exists(a) ? gold[a] : init_val(a);
    endfunction

    typedef struct {
        logic        hit;
        logic        rd;
        logic [15:0] data;
        int          base;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] exp_rd [$];
    logic [31:0] exp_wr [$];

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (m_rd && m_wr)
                chk("strobe_excl", 32'({m_rd, m_wr}), 32'd1);
            if (!Stall)
                chk("strobe_idle", 32'(m_rd | m_wr), 32'd0);
            if ((m_rd || m_wr) && m_stall)
                stall_total++;
            if (m_rd && !m_stall) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_m_rd: addr %h, none expected", m_addr);
                end else begin
                    chk("m_rd_addr", 32'(m_addr), 32'(exp_rd.pop_front()));
                end
            end
            if (m_wr && !m_stall) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_m_wr: addr %h data %h, none expected", m_addr, m_data_in);
                end else begin
                    chk("m_wr_addr_data", {m_addr, m_data_in}, exp_wr.pop_front());
                end
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: Done=1 with no access outstanding");
                end else begin
                    e = sb.pop_front();
                    chk("cache_hit", 32'(CacheHit), 32'(e.hit));
                    if (e.rd)
                        chk("read_data", 32'(DataOut), 32'(e.data));
                    chk("latency", cyc - start_cyc,
                        e.base + (e.hit ? 0 : stall_total - start_stall));
                end
            end
        end
    end

    task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t       e;
        logic [7:0] idx;
        logic [4:0] tag;
        int         n_stall;
        logic       got;
        idx = addr[10:3];
        tag = addr[15:11];
        e.hit  = rv[idx] && rt[idx] == tag;
        e.rd   = rd;
        e.base = 0;
        if (!e.hit) begin
            e.base = 7;
            if (rv[idx] && rdty[idx]) begin
                e.base = 11;
                for (int w = 0; w < 4; w++) begin
                    logic [15:0] va;
                    va = {rt[idx], idx, 2'(w), 1'b0};
                    exp_wr.push_back({va, gold_rd(int'(va[15:1]))});
                end
            end
            for (int w = 0; w < 4; w++)
                exp_rd.push_back({tag, idx, 2'(w), 1'b0});
        end
        e.data = gold_rd(int'(addr[15:1]));
        if (!rd)
            gold[int'(addr[15:1])] = wdata;
        rdty[idx] = e.hit ? (rdty[idx] | !rd) : !rd;
        rv[idx] = 1'b1;
        rt[idx] = tag;
        sb.push_back(e);

        Rd = rd; Wr = !rd; Addr = addr; DataIn = wdata;
        start_cyc = cyc;
        start_stall = stall_total;
        n_stall = 0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0)
                chk("err_low", 32'(Err), 32'd0);
            if (Stall)
                n_stall++;
            if (Done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %h no Done within 200 cycles", addr);
        end else begin
            last_lat = cyc - start_cyc;
            chk("stall_cycles", n_stall, last_lat - (e.hit ? 0 : 1));
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        logic [15:0] old3;
        for (int i = 0; i < 256; i++) begin
            rv[i] = 1'b0; rdty[i] = 1'b0; rt[i] = '0;
        end

        // Reset, with a request present that must be ignored.
        @(posedge clk); #1;
        Rd = 1'b1; Addr = 16'h0010;
        @(negedge clk);
        chk("reset_outs", 32'({Done, Stall, CacheHit, Err, c_enable, m_rd, m_wr}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0;

        // Cold read miss, then hit on the same line.
        access(1'b1, 16'h0010, 16'h0);
        chk("clean_miss_lat", last_lat, 7);
        access(1'b1, 16'h0012, 16'h0);
        chk("hit_lat", last_lat, 0);

        // Write hit dirties the line; conflicting read forces writeback.
        access(1'b0, 16'h0014, 16'hBEEF);
        access(1'b1, 16'h0814, 16'h0);
        chk("dirty_miss_lat", last_lat, 11);
        access(1'b1, 16'h0014, 16'h0);

        // Rd and Wr together.
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010;
        @(negedge clk);
        chk("err_high", 32'(Err), 32'd1);
        chk("err_no_cache", 32'(c_enable), 32'd0);
        chk("err_no_mem", 32'(m_rd | m_wr), 32'd0);
        chk("err_stall", 32'(Stall), 32'd0);
        chk("err_done", 32'(Done), 32'd0);
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        chk("err_one_cycle", 32'(Err), 32'd0);
        @(posedge clk); #1;

        // Three-cycle memory stall on the second fill request.
        stall_mode = 2;
        access(1'b1, 16'h0200, 16'h0);
        chk("stall_miss_lat", last_lat, 10);
        stall_mode = 0;

        // Reset while waiting for fill returns.
        old3 = cw[8'h20][3];
        for (int w = 0; w < 4; w++)
            exp_rd.push_back({5'd2, 8'h20, 2'(w), 1'b0});
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h1100;
        start_cyc = cyc;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rdwait_stall", 32'(Stall), 32'd1);
        rst = 1'b1; Rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_no_fill", 32'(c_enable), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("late_word_dropped", 32'(cw[8'h20][3]), 32'(old3));
        inv_idx = 8'h20; inv_req = 1'b1;
        @(posedge clk); #1;
        inv_req = 1'b0;
        rv[8'h20] = 1'b0;

        // Random traffic over a few conflicting indices with random memory stalls.
        stall_mode = 1;
        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            a = {5'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0};
            access(1'($urandom_range(0, 1)), a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        stall_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("rd_drained", exp_rd.size(), 0);
        chk("wr_drained", exp_wr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Controller FSM for the direct-mapped cache subsystem.
- Sits between the CPU memory port, one direct-mapped cache array (one 4-word line per index) and the four-bank main memory.
- Handles single-cycle hits. On a miss, it writes back a dirty victim, fills the line from memory, then replays the original access.
- The encoded state lives in a 3-bit registered state vector; all control outputs are decoded from it.

Parameters:
- MEM_LAT, 2, cycles from an accepted memory read to data valid on mem_data_out.
- WORDS, 4, 16-bit words per cache line (fixed at 4; offset[2:1] selects the word).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- Rd  in  1  CPU read request.
- Wr  in  1  CPU write request.
- Addr  in  16  CPU byte address: tag=[15:11], index=[10:3], offset=[2:0].
- DataIn  in  16  CPU write data.
- DataOut  out  16  read data, valid when Done=1.
- Done  out  1  access complete (1-cycle pulse).
- Stall  out  1  controller busy; CPU holds request inputs.
- CacheHit  out  1  access completed as a first-try hit.
- Err  out  1  Rd and Wr both high in IDLE.
- c_enable, c_comp, c_write, c_valid_in  out  1 each  cache control.
- c_tag_in  out  5  cache tag.
- c_index  out  8  cache index.
- c_offset  out  3  cache offset.
- c_data_in  out  16  cache write data.
- c_hit, c_dirty, c_valid  in  1 each  cache status.
- c_tag_out  in  5  victim tag.
- c_data_out  in  16  cache read data.
- m_addr  out  16  memory address.
- m_data_in  out  16  memory write data.
- m_wr, m_rd  out  1 each  memory request.
- m_stall  in  1  memory cannot accept a request this cycle.
- m_data_out  in  16  memory read data.

Behaviour:
- States: IDLE, WB, RDREQ, RDWAIT, REDO.
- Reset: state=IDLE; word counters and the return pipeline are cleared. All outputs are 0, except cache/memory address buses, which are don't-care.

IDLE:
- Stall=0.
- If Rd^Wr: drive the cache combinationally with c_enable=1, c_comp=1, c_write=Wr, tag/index/offset from Addr, c_data_in=DataIn.
- Hit is (c_hit & c_valid). On a hit: Done=1, CacheHit=1, DataOut=c_data_out, stay in IDLE. Hit latency is 0 cycles.
- On a miss: latch Addr, DataIn and the op. Go to WB if (c_valid & c_dirty), else RDREQ. Stall=0 in the detect cycle.
- If Rd&Wr: Err=1 for that cycle; no cache or memory access; stay in IDLE.

WB (dirty victim writeback):
- Cache: c_comp=0, c_write=0, c_offset={wcnt,0}.
- Memory: m_wr=1, m_addr={c_tag_out, index, wcnt, 0}, m_data_in=c_data_out.
- wcnt increments only when m_stall=0.
- After wcnt=3 is accepted, go to RDREQ.

RDREQ (line fill requests):
- Memory: m_rd=1, m_addr={latched tag, index, rcnt, 0}.
- rcnt increments only when m_stall=0.
- Each accepted read pushes its word number into a MEM_LAT-deep valid/offset pipeline.
- After rcnt=3 is accepted, go to RDWAIT.

Fill writes (in RDREQ or RDWAIT, whenever the pipeline head is valid):
- Cache: c_enable=1, c_comp=0, c_write=1, c_valid_in=1, c_tag_in=latched tag, c_offset={word,0}, c_data_in=m_data_out.

RDWAIT:
- When the 4th returned word is written, go to REDO.

REDO:
- Replay the latched access with c_comp=1. A write sets the dirty bit through the cache compare-write.
- Done=1, CacheHit=0, DataOut=c_data_out (reads); Stall=0; next state IDLE.

Stall and Done:
- Stall=1 in WB, RDREQ and RDWAIT.
- Done is never asserted outside IDLE-hit and REDO.

Miss latency (m_stall=0, counted from the detect cycle 0):
- Clean miss: reads in cycles 1–4, returns in cycles 3–6, Done in cycle 7.
- Dirty miss: Done in cycle 11.

Boundary conditions:
- m_stall during WB or RDREQ holds the counter and issues no new request; outstanding returns still drain.
- Memory request strobes are never asserted in IDLE, RDWAIT or REDO.
- rst mid-operation returns to IDLE next cycle. In-flight memory returns are discarded; the partially filled line is left as-is.

Test Plan:
- Reset, then Rd Addr=0x0010 to a cold cache -> Err=0; Stall high cycles 1–6; four m_rd at 0x0010/12/14/16; Done=1, CacheHit=0 at cycle 7.
- Repeat Rd 0x0012 -> Done=1, CacheHit=1 in the same cycle; no m_rd/m_wr.
- Wr 0x0014 data 0xBEEF (hit, sets dirty), then Rd 0x0814 (same index, tag 1) -> four m_wr at 0x0010–0x0016 with 0xBEEF at 0x0014; then four m_rd at 0x0810–0x0816; Done at cycle 11.
- Clean miss with m_stall=1 on the 2nd read request for 3 cycles -> rcnt holds, no duplicate address issued, Done delayed by exactly 3 cycles.
- Rd=Wr=1 in IDLE -> Err=1 for one cycle, no cache enable, no memory strobe, Stall=0.
- Assert rst during RDWAIT -> next cycle state=IDLE, Stall=0, Done=0; late m_data_out is not written to the cache.
